// File: rtl/arm_pkg.sv
// Shared definitions for the ARM register-specified shift path.
// Provides the 2-bit shift-type encodings, the sequencer FSM state type and
// a helper that maps (shift_type, amount) to the number of single-bit steps
// the shifter must perform to reach the architectural result.
package arm_pkg;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Counts beyond 33 (LSL/LSR) or 32 (ASR) give the same result and carry,
    // so they are clamped. ROR is modulo 32, but a nonzero multiple of 32 must
    // still rotate a full turn so the carry becomes bit 31.
    function automatic logic [5:0] eff_count(input logic [1:0] shift_type,
                                             input logic [7:0] amount);
        logic [5:0] eff;
        eff = 6'd0;
        case (shift_type)
            SHIFT_LSL, SHIFT_LSR: eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
            SHIFT_ASR:            eff = (amount > 8'd32) ? 6'd32 : amount[5:0];
            default: begin
                if (amount[4:0] == 5'd0 && amount != 8'd0) begin
                    eff = 6'd32;
                end else begin
                    eff = {1'b0, amount[4:0]};
                end
            end
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift step: moves a 32-bit value by n (0..32) bit positions.
// Ports:
//   value      in  32  value before the step
//   shift_type in  2   LSL/LSR/ASR/ROR
//   n          in  6   bits to move this step; 0 passes value and carry through
//   carry      in  1   carry before the step
//   shifted    out 32  value after the step
//   carry_new  out 1   last bit shifted out (ROR: new bit 31)
module shift_step
    import arm_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  shift_type,
    input  logic [5:0]  n,
    input  logic        carry,
    output logic [31:0] shifted,
    output logic        carry_new
);

    // One extra bit on the outgoing side captures the last bit shifted out.
    logic [32:0] lsl_ext;
    logic [32:0] lsr_ext;
    logic [32:0] asr_ext;
    logic [63:0] ror_ext;

    always_comb begin
        lsl_ext   = {1'b0, value} << n;
        lsr_ext   = {value, 1'b0} >> n;
        asr_ext   = $signed({value, 1'b0}) >>> n;
        ror_ext   = {value, value} >> n[4:0];
        shifted   = value;
        carry_new = carry;
        if (n != 6'd0) begin
            case (shift_type)
                SHIFT_LSL: begin
                    shifted   = lsl_ext[31:0];
                    carry_new = lsl_ext[32];
                end
                SHIFT_LSR: begin
                    shifted   = lsr_ext[32:1];
                    carry_new = lsr_ext[0];
                end
                SHIFT_ASR: begin
                    shifted   = asr_ext[32:1];
                    carry_new = asr_ext[0];
                end
                default: begin
                    shifted   = ror_ext[31:0];
                    carry_new = ror_ext[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer for ARM register-specified shifts (Rm shifted by Rs[7:0]).
// Moves at most STEP bits per cycle through a single shift_step unit.
// Ports:
//   clk, reset(active-low async), flush(sync abort)
//   req_valid/req_ready, shift_type, rrx, amount, rm_data, carry_in : request side
//   res_valid/res_ready, result, carry_out                           : result side
module shift_sequencer
    import arm_pkg::*;
#(
    parameter int unsigned STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  shift_type,
    input  logic        rrx,
    input  logic [7:0]  amount,
    input  logic [31:0] rm_data,
    input  logic        carry_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        carry_out
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_e      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] val_q, val_d;
    logic        carry_q, carry_d;
    logic [5:0]  rem_q, rem_d;

    logic [5:0]  eff;
    logic [5:0]  step_n;
    logic [31:0] step_val;
    logic        step_carry;
    logic        accept;

    assign eff       = eff_count(shift_type, amount);
    assign step_n    = (rem_q < STEP_W) ? rem_q : STEP_W;
    assign req_ready = (state_q == StIdle);
    assign res_valid = (state_q == StDone);
    assign accept    = req_valid && req_ready && !flush;
    assign result    = val_q;
    assign carry_out = carry_q;

    shift_step u_shift_step (
        .value      (val_q),
        .shift_type (type_q),
        .n          (step_n),
        .carry      (carry_q),
        .shifted    (step_val),
        .carry_new  (step_carry)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        val_d   = val_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = StIdle;
            type_d  = 2'd0;
            val_d   = 32'd0;
            carry_d = 1'b0;
            rem_d   = 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        type_d = shift_type;
                        if (shift_type == SHIFT_ROR && rrx) begin
                            // RRX is a single fixed move; finish it directly.
                            val_d   = {carry_in, rm_data[31:1]};
                            carry_d = rm_data[0];
                            rem_d   = 6'd0;
                            state_d = StDone;
                        end else begin
                            val_d   = rm_data;
                            carry_d = carry_in;
                            rem_d   = eff;
                            state_d = (eff == 6'd0) ? StDone : StShift;
                        end
                    end
                end
                StShift: begin
                    val_d   = step_val;
                    carry_d = step_carry;
                    rem_d   = rem_q - step_n;
                    if (rem_q <= STEP_W) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            type_q  <= 2'd0;
            val_q   <= 32'd0;
            carry_q <= 1'b0;
            rem_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            val_q   <= val_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a reference model pushes the
// expected result, carry and latency at request time; a monitor pops and
// compares when the DUT presents a result.
module tb_shift_sequencer;

    localparam int unsigned STEP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  shift_type = 2'd0;
    logic        rrx = 1'b0;
    logic [7:0]  amount = 8'd0;
    logic [31:0] rm_data = 32'd0;
    logic        carry_in = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic was_valid = 1'b0;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .shift_type (shift_type),
        .rrx        (rrx),
        .amount     (amount),
        .rm_data    (rm_data),
        .carry_in   (carry_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .carry_out  (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of a register-specified shift.
    function automatic exp_t model(input logic [1:0] t, input logic x, input logic [7:0] a,
                                   input logic [31:0] rm, input logic ci);
        exp_t e;
        int   eff;
        int   ai;
        int   r;
        ai = int'(a);
        if (t == 2'b11 && x) begin
            e.res = {ci, rm[31:1]};
            e.c   = rm[0];
            e.lat = 1;
            return e;
        end
        case (t)
            2'b00, 2'b01: eff = (ai > 33) ? 33 : ai;
            2'b10:        eff = (ai > 32) ? 32 : ai;
            default:      eff = (ai % 32 == 0 && ai != 0) ? 32 : ai % 32;
        endcase
        e.lat = (eff == 0) ? 1 : (eff + int'(STEP) - 1) / int'(STEP) + 1;
        e.res = rm;
        e.c   = ci;
        if (ai != 0) begin
            case (t)
                2'b00: begin
                    if (ai < 32) begin
                        e.res = rm << ai;
                        e.c   = rm[32 - ai];
                    end else begin
                        e.res = 32'd0;
                        e.c   = (ai == 32) ? rm[0] : 1'b0;
                    end
                end
                2'b01: begin
                    if (ai < 32) begin
                        e.res = rm >> ai;
                        e.c   = rm[ai - 1];
                    end else begin
                        e.res = 32'd0;
                        e.c   = (ai == 32) ? rm[31] : 1'b0;
                    end
                end
                2'b10: begin
                    if (ai < 32) begin
                        e.res = $signed(rm) >>> ai;
                        e.c   = rm[ai - 1];
                    end else begin
                        e.res = {32{rm[31]}};
                        e.c   = rm[31];
                    end
                end
                default: begin
                    r = ai % 32;
                    e.res = (r == 0) ? rm : ((rm >> r) | (rm << (32 - r)));
                    e.c   = e.res[31];
                end
            endcase
        end
        return e;
    endfunction

    // Result-side monitor: latency on first valid, value every valid cycle
    // (covers stability while stalled), pop on handshake.
    always @(negedge clk) begin
        if (reset && res_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(res_valid), 64'd0);
            end else begin
                if (!was_valid) check("latency", 64'(cyc - acc_cyc + 1), 64'(sb[0].lat));
                check("result", 64'(result), 64'(sb[0].res));
                check("carry_out", 64'(carry_out), 64'(sb[0].c));
                check("req_ready_in_done", 64'(req_ready), 64'd0);
                if (res_ready && !flush) void'(sb.pop_front());
            end
        end
        was_valid <= reset && res_valid;
    end

    task automatic run_op(input logic [1:0] t, input logic x, input logic [7:0] a,
                          input logic [31:0] rm, input logic ci, input int hold);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        shift_type = t;
        rrx        = x;
        amount     = a;
        rm_data    = rm;
        carry_in   = ci;
        req_valid  = 1'b1;
        sb.push_back(model(t, x, a, rm, ci));
        acc_cyc = cyc + 1;
        step();
        // Scramble request inputs while busy; they must be ignored.
        req_valid  = 1'b0;
        shift_type = 2'($urandom);
        rrx        = 1'($urandom);
        amount     = 8'($urandom);
        rm_data    = $urandom;
        carry_in   = 1'($urandom);
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        if (!res_valid) begin
            check("res_valid_timeout", 64'd0, 64'd1);
            sb.delete();
            return;
        end
        repeat (hold) begin
            step();
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("post_done_req_ready", 64'(req_ready), 64'd1);
        check("post_done_res_valid", 64'(res_valid), 64'd0);
    endtask

    logic [7:0] amt_tbl [12] = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd9, 8'd31, 8'd32, 8'd33,
                                 8'd34, 8'd64, 8'd200, 8'd255};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_carry", 64'(carry_out), 64'd0);
        repeat (3) step();
        reset = 1'b1;
        step();

        // Directed cases.
        run_op(2'b00, 1'b0, 8'd4,   32'h8000_0001, 1'b1, 0);
        run_op(2'b01, 1'b0, 8'd40,  32'hFFFF_FFFF, 1'b1, 0);
        run_op(2'b01, 1'b0, 8'd32,  32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'b10, 1'b0, 8'd200, 32'h8000_0000, 1'b0, 0);
        run_op(2'b11, 1'b0, 8'd64,  32'h8000_0000, 1'b0, 0);
        run_op(2'b00, 1'b0, 8'd0,   32'hDEAD_BEEF, 1'b1, 0);
        run_op(2'b11, 1'b1, 8'd77,  32'h0000_0003, 1'b1, 0);
        run_op(2'b00, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 5);
        run_op(2'b00, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 1);
        run_op(2'b11, 1'b0, 8'd4,   32'h0000_0008, 1'b0, 2);

        // Random mix with boundary amounts and random stalls.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(1, 0) == 1) ? amt_tbl[$urandom_range(11, 0)] : 8'($urandom);
            run_op(2'($urandom), 1'($urandom), a, $urandom, 1'($urandom),
                   int'($urandom_range(3, 0)));
        end

        // Flush in IDLE with a pending request: no accept.
        step();
        req_valid = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle_no_accept", 64'(req_ready), 64'd1);

        // Flush in SHIFT with req_valid held high.
        shift_type = 2'b00;
        rrx        = 1'b0;
        amount     = 8'd20;
        rm_data    = 32'h1234_5678;
        carry_in   = 1'b1;
        req_valid  = 1'b1;
        step();
        check("flush_busy", 64'(req_ready), 64'd0);
        step();
        flush = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_req_ready", 64'(req_ready), 64'd1);
        check("flush_res_valid", 64'(res_valid), 64'd0);
        check("flush_result", 64'(result), 64'd0);
        check("flush_carry", 64'(carry_out), 64'd0);
        repeat (6) begin
            step();
            check("flush_no_valid", 64'(res_valid), 64'd0);
        end

        // Reset pulse mid-SHIFT.
        shift_type = 2'b01;
        amount     = 8'd30;
        rm_data    = 32'hF0F0_F0F0;
        carry_in   = 1'b1;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        step();
        reset = 1'b1;
        repeat (4) begin
            step();
            check("rst_no_valid", 64'(res_valid), 64'd0);
        end

        // Normal operation after reset.
        run_op(2'b10, 1'b0, 8'd5, 32'h8000_00F0, 1'b0, 1);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
